// File: rtl/alu4_op_issue.sv
// alu4_op_issue: FIFO-buffered, registered valid/ready issue stage feeding the 4-bit ALU.
// Optional macro ALU4_ISSUE_FWD_EN adds forwarding of the previous ALU result as operand a.
module alu4_op_issue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_a,
    input  logic [3:0]             in_b,
    input  logic [1:0]             in_sel,
`ifdef ALU4_ISSUE_FWD_EN
    input  logic                   in_fwd,
    input  logic [3:0]             alu_res,
`endif
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [3:0]             issue_a,
    output logic [3:0]             issue_b,
    output logic [1:0]             issue_sel,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic [CNT_W-1:0]       issued_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] sel;
`ifdef ALU4_ISSUE_FWD_EN
        logic       fwd;
`endif
    } entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1
`ifdef ALU4_ISSUE_FWD_EN
        ,
        BUBBLE = 2'd2
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   count_q, count_d;
    logic               issue_valid_q, issue_valid_d;
    logic [3:0]         issue_a_q, issue_a_d;
    logic [3:0]         issue_b_q, issue_b_d;
    logic [1:0]         issue_sel_q, issue_sel_d;
    logic [CNT_W-1:0]   issued_cnt_q, issued_cnt_d;
    entry_t             mem_q [DEPTH];
    entry_t             wr_entry_d;
    entry_t             head_c;

    logic               full_c;
    logic               empty_c;
    logic               push_c;
    logic               fire_c;
    logic               load_c;

    assign full_c  = (count_q == OCC_W'(DEPTH));
    assign empty_c = (count_q == OCC_W'(0));
    assign push_c  = in_valid && !full_c;
    assign fire_c  = issue_valid_q && issue_ready;
    assign head_c  = mem_q[rd_ptr_q];

    // Issue FSM: decides when the head entry moves into the issue registers.
    always_comb begin
        state_d       = state_q;
        issue_valid_d = issue_valid_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        issue_sel_d   = issue_sel_q;
        load_c        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty_c) begin
                    load_c  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (fire_c) begin
                    if (empty_c) begin
                        state_d       = IDLE;
                        issue_valid_d = 1'b0;
                    end
`ifdef ALU4_ISSUE_FWD_EN
                    // alu_res only reflects the op firing now after this edge.
                    else if (head_c.fwd) begin
                        state_d       = BUBBLE;
                        issue_valid_d = 1'b0;
                    end
`endif
                    else begin
                        load_c = 1'b1;
                    end
                end
            end
`ifdef ALU4_ISSUE_FWD_EN
            BUBBLE: begin
                if (!empty_c) begin
                    load_c  = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d       = IDLE;
                issue_valid_d = 1'b0;
            end
        endcase

        if (load_c) begin
            issue_valid_d = 1'b1;
`ifdef ALU4_ISSUE_FWD_EN
            issue_a_d     = head_c.fwd ? alu_res : head_c.a;
`else
            issue_a_d     = head_c.a;
`endif
            issue_b_d     = head_c.b;
            issue_sel_d   = head_c.sel;
        end
    end

    // FIFO bookkeeping and issue counter.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        issued_cnt_d   = issued_cnt_q;
        wr_entry_d.a   = in_a;
        wr_entry_d.b   = in_b;
        wr_entry_d.sel = in_sel;
`ifdef ALU4_ISSUE_FWD_EN
        wr_entry_d.fwd = in_fwd;
`endif
        count_d        = count_q + OCC_W'(push_c) - OCC_W'(load_c);

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (load_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (fire_c) begin
            issued_cnt_d = issued_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_sel_q   <= '0;
            issued_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            issue_sel_q   <= issue_sel_d;
            issued_cnt_q  <= issued_cnt_d;
        end
    end

    // Entry storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_entry_d;
        end
    end

    assign in_ready    = !full_c;
    assign full        = full_c;
    assign empty       = empty_c;
    assign count       = count_q;
    assign issue_valid = issue_valid_q;
    assign issue_a     = issue_a_q;
    assign issue_b     = issue_b_q;
    assign issue_sel   = issue_sel_q;
    assign issued_cnt  = issued_cnt_q;

endmodule

// File: tb/tb_alu4_op_issue.sv
// Self-checking bench for alu4_op_issue: directed steps plus random traffic against a queue model.
module tb_alu4_op_issue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;
`ifdef ALU4_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] sel;
        logic       fwd;
    } op_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_a = '0;
    logic [3:0]       in_b = '0;
    logic [1:0]       in_sel = '0;
    logic             fwd_in = 1'b0;
    logic [3:0]       alu_res;
    logic             issue_valid;
    logic             issue_ready = 1'b0;
    logic [3:0]       issue_a;
    logic [3:0]       issue_b;
    logic [1:0]       issue_sel;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] issued_cnt;

    alu4_op_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_sel      (in_sel),
`ifdef ALU4_ISSUE_FWD_EN
        .in_fwd      (fwd_in),
        .alu_res     (alu_res),
`endif
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .issue_sel   (issue_sel),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .issued_cnt  (issued_cnt)
    );

    always #5 clk = ~clk;

    // Downstream ALU: registers its result on every accepted op.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_res <= '0;
        end else if (issue_valid && issue_ready) begin
            case (issue_sel)
                2'b00:   alu_res <= issue_a + issue_b;
                2'b01:   alu_res <= issue_a - issue_b;
                2'b10:   alu_res <= issue_a & issue_b;
                default: alu_res <= issue_a | issue_b;
            endcase
        end
    end

    // Reference model state: pending ops in order, plus the op currently offered.
    op_t              q[$];
    op_t              m_op;
    bit               m_valid;
    bit               m_bubble;
    logic [CNT_W-1:0] m_cnt;
    int               tests;
    int               fails;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("count", 32'(count), 32'(q.size()));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        check("issue_valid", 32'(issue_valid), 32'(m_valid));
        check("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
        if (m_valid) begin
            check("issue_a", 32'(issue_a), 32'(m_op.a));
            check("issue_b", 32'(issue_b), 32'(m_op.b));
            check("issue_sel", 32'(issue_sel), 32'(m_op.sel));
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] s, input bit f);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_sel   = s;
        fwd_in   = FWD ? f : 1'b0;
    endtask

    // One clock: predict the edge from the pre-edge model, then compare at negedge.
    task automatic tick();
        op_t ld;
        op_t pushed;
        bit  push;
        bit  fire;
        bit  load;
        bit  bub_n;
        push   = in_valid && (q.size() < DEPTH);
        fire   = m_valid && issue_ready;
        load   = 1'b0;
        bub_n  = 1'b0;
        pushed = '{a: in_a, b: in_b, sel: in_sel, fwd: fwd_in};
        if (m_bubble) begin
            load = (q.size() > 0);
        end else if ((!m_valid || fire) && q.size() > 0) begin
            if (FWD && fire && q[0].fwd) bub_n = 1'b1;
            else load = 1'b1;
        end
        if (load) begin
            ld = q.pop_front();
            if (ld.fwd) ld.a = alu_res;
            m_op = ld;
        end
        if (push) q.push_back(pushed);
        if (fire) m_cnt = m_cnt + 1'b1;
        m_valid  = load ? 1'b1 : (fire ? 1'b0 : m_valid);
        m_bubble = bub_n;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic drain();
        in_valid    = 1'b0;
        issue_ready = 1'b1;
        for (int i = 0; i < 40 && (q.size() > 0 || m_valid || m_bubble); i++) tick();
        check("drain_done", 32'(q.size() > 0 || m_valid || m_bubble), 32'd0);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        issue_ready = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_valid", 32'(issue_valid), 32'd0);
        check("rst_a", 32'(issue_a), 32'd0);
        check("rst_b", 32'(issue_b), 32'd0);
        check("rst_sel", 32'(issue_sel), 32'd0);
        check("rst_issued", 32'(issued_cnt), 32'd0);
        q.delete();
        m_valid  = 1'b0;
        m_bubble = 1'b0;
        m_op     = '0;
        m_cnt    = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        m_valid  = 1'b0;
        m_bubble = 1'b0;
        m_op     = '0;
        m_cnt    = '0;

        @(negedge clk);
        do_reset();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single op: visible one cycle after the push, then fires.
        issue_ready = 1'b1;
        drive(1'b1, 4'd3, 4'd5, 2'b00, 1'b0);
        tick();
        check("t1_no_bypass", 32'(issue_valid), 32'd0);
        drive(1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
        tick();
        check("t1_valid", 32'(issue_valid), 32'd1);
        check("t1_a", 32'(issue_a), 32'd3);
        check("t1_b", 32'(issue_b), 32'd5);
        check("t1_sel", 32'(issue_sel), 32'd0);
        tick();
        check("t1_issued", 32'(issued_cnt), 32'd1);
        check("t1_empty", 32'(empty), 32'd1);

        // Fill with the sink stalled; 6th op must wait for room.
        issue_ready = 1'b0;
        drive(1'b1, 4'd9, 4'd2, 2'b01, 1'b0);  tick();
        drive(1'b1, 4'd4, 4'd4, 2'b10, 1'b0);  tick();
        drive(1'b1, 4'd1, 4'd7, 2'b11, 1'b0);  tick();
        drive(1'b1, 4'd6, 4'd6, 2'b00, 1'b0);  tick();
        check("t2_count3", 32'(count), 32'd3);
        drive(1'b1, 4'd15, 4'd1, 2'b01, 1'b0); tick();
        check("t2_full", 32'(full), 32'd1);
        check("t2_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 4'd2, 4'd14, 2'b10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_a", 32'(issue_a), 32'd9);
            check("t3_hold_b", 32'(issue_b), 32'd2);
            check("t3_hold_sel", 32'(issue_sel), 32'd1);
            check("t3_held_count", 32'(count), 32'd4);
        end
        issue_ready = 1'b1;
        tick();
        check("t3_next_valid", 32'(issue_valid), 32'd1);
        check("t3_next_a", 32'(issue_a), 32'd4);
        check("t3_count_after", 32'(count), 32'd3);
        tick();
        check("t3_late_push_count", 32'(count), 32'd3);
        drain();
        check("t3_issued_total", 32'(issued_cnt), 32'd7);

        // Reset while busy discards everything.
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b0);
            tick();
        end
        check("t4_pre_count", 32'(count), 32'd3);
        check("t4_pre_valid", 32'(issue_valid), 32'd1);
        do_reset();
        issue_ready = 1'b1;
        drive(1'b1, 4'd7, 4'd8, 2'b11, 1'b0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
        tick();
        check("t4_post_a", 32'(issue_a), 32'd7);
        tick();
        check("t4_post_issued", 32'(issued_cnt), 32'd1);

        // 300-op stream at full rate: counter wraps to 44.
        do_reset();
        issue_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b0);
            tick();
        end
        drain();
        check("t5_issued_wrap", 32'(issued_cnt), 32'd44);

        // Random producer/consumer traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom_range(0, 1)));
            issue_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

`ifdef ALU4_ISSUE_FWD_EN
        // Forwarded op after a fire waits one bubble for the fresh ALU result.
        do_reset();
        issue_ready = 1'b1;
        drive(1'b1, 4'd2, 4'd3, 2'b00, 1'b0); tick();
        drive(1'b1, 4'd0, 4'd1, 2'b01, 1'b1); tick();
        drive(1'b0, 4'd0, 4'd0, 2'b00, 1'b0); tick();
        check("t6_bubble", 32'(issue_valid), 32'd0);
        tick();
        check("t6_valid", 32'(issue_valid), 32'd1);
        check("t6_fwd_a", 32'(issue_a), 32'd5);
        check("t6_b", 32'(issue_b), 32'd1);
        check("t6_sel", 32'(issue_sel), 32'd1);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
